adc_spi_responder: RTL and testbench

- Synthesizable emulation of the 8-channel 12-bit serial ADC as seen from the SPI master that polls it (ADC_SCLK/ADC_CS_N/ADC_SADDR in, ADC_SDAT out).
- Lets the gyroscope path and IMU firmware run in hardware-in-loop without the physical ADC. Channel values are loaded through a register write port.
- Decodes the channel address clocked in on ADC_SADDR and returns the selected channel's value on ADC_SDAT, one frame later, matching the real part.

---
 rtl/adc_spi_responder.sv | 154 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates an 8-channel 12-bit serial ADC as seen by the SPI master that polls it.
// The master inputs are synchronized into clk. The channel address is captured on
// SCLK rises 3..5. The value of the channel addressed in the previous frame is
// shifted out MSB first: four leading zeros, then DB11..DB0.
//
// Ports:
//   clk          system clock (at least 8x SCLK)
//   reset_n      asynchronous active-low reset
//   adc_sclk     serial clock from master (async)
//   adc_cs_n     chip select from master, active low (async)
//   adc_saddr    address bit stream from master (async)
//   adc_sdat     serial data to master, MSB first
//   wr_en        channel register write strobe
//   wr_addr      channel index written
//   wr_data      channel value written
//   frame_done   one-clk pulse when a frame completes (SCLK rise FRAME_BITS)
//   frame_addr   address decoded in the last completed frame
//   frame_abort  one-clk pulse when CS rises mid-frame
//
// Handshake: there is no valid/ready pair. wr_en is a single-cycle write strobe.
// frame_done and frame_abort are single-cycle event pulses. Neither pulse waits
// for any acknowledge.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_sclk,
    input  logic        adc_cs_n,
    input  logic        adc_saddr,
    output logic        adc_sdat,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic        frame_done,
    output logic [2:0]  frame_addr,
    output logic        frame_abort
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  saddr_sync;
    logic                    sclk_prev;
    logic                    cs_prev;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CW-1:0]           rise_cnt;
    logic [CW-1:0]           fall_cnt;
    logic [2:0]              addr_cap;
    logic [2:0]              next_addr;
    logic [11:0]             ch [8];

    logic s_sclk, s_cs, s_saddr;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [FRAME_BITS-1:0] load_word;

    assign s_sclk    = sclk_sync[SYNC_STAGES-1];
    assign s_cs      = cs_sync[SYNC_STAGES-1];
    assign s_saddr   = saddr_sync[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_prev;
    assign sclk_fall = ~s_sclk & sclk_prev;
    assign cs_rise   = s_cs & ~cs_prev;
    assign cs_fall   = ~s_cs & cs_prev;
    // The register file is read with its pre-write contents.
    // A load that coincides with a write therefore returns the old value.
    assign load_word = {{(FRAME_BITS-12){1'b0}}, ch[next_addr]};

    // adc_sdat decodes flops only, so it drops to 0 the instant reset asserts.
    assign adc_sdat = (state == ACTIVE) & shreg[FRAME_BITS-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // The CS chain resets low. A CS already held low at release then
            // produces no falling edge, and the FSM waits for a fresh fall.
            sclk_sync   <= '0;
            cs_sync     <= '0;
            saddr_sync  <= '0;
            sclk_prev   <= 1'b0;
            cs_prev     <= 1'b0;
            state       <= IDLE;
            shreg       <= '0;
            rise_cnt    <= '0;
            fall_cnt    <= '0;
            addr_cap    <= '0;
            next_addr   <= '0;
            frame_addr  <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            for (int i = 0; i < 8; i++) ch[i] <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            saddr_sync  <= {saddr_sync[SYNC_STAGES-2:0], adc_saddr};
            sclk_prev   <= s_sclk;
            cs_prev     <= s_cs;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            if (wr_en) ch[wr_addr] <= wr_data;

            case (state)
                IDLE: begin
                    // SCLK is ignored here. A CS fall wins over a coincident SCLK edge.
                    if (cs_fall) begin
                        shreg    <= load_word;
                        rise_cnt <= '0;
                        fall_cnt <= '0;
                        addr_cap <= '0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // A CS rise wins over any SCLK edge in the same cycle.
                        if (rise_cnt != '0 || fall_cnt != '0) frame_abort <= 1'b1;
                        addr_cap <= '0;
                        state    <= IDLE;
                    end else if (sclk_rise) begin
                        // rise_cnt holds the count before this rise: 2,3,4 = rises 3,4,5.
                        if (rise_cnt == CW'(2)) addr_cap[2] <= s_saddr;
                        if (rise_cnt == CW'(3)) addr_cap[1] <= s_saddr;
                        if (rise_cnt == CW'(4)) addr_cap[0] <= s_saddr;
                        if (rise_cnt == CW'(FRAME_BITS - 1)) begin
                            next_addr  <= addr_cap;
                            frame_addr <= addr_cap;
                            frame_done <= 1'b1;
                            rise_cnt   <= '0;
                        end else begin
                            rise_cnt <= rise_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (fall_cnt == CW'(FRAME_BITS - 1)) begin
                            // The final fall follows the final rise. next_addr is already
                            // updated, so the reload serves a back-to-back frame with CS low.
                            shreg    <= load_word;
                            fall_cnt <= '0;
                        end else begin
                            shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
                            fall_cnt <= fall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder.
// SCLK idles low. Each bit is sampled just before its SCLK rise.
module tb_adc_spi_responder;

    localparam int SYNC = 2;
    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic        clk = 1'b0;
    logic        reset_n;
    logic        adc_sclk, adc_cs_n, adc_saddr;
    logic        adc_sdat;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_done, frame_abort;
    logic [2:0]  frame_addr;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    adc_spi_responder #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_saddr(adc_saddr),
        .adc_sdat(adc_sdat),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_addr(frame_addr), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    // Count pulse-high cycles away from the active edge.
    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp_data;
        logic [2:0]  exp_faddr;
    } frame_vec_t;

    frame_vec_t sep_vec [4];
    frame_vec_t cont_vec [8];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_ch(input logic [2:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        wait_clk(1);
        wr_en = 1'b0;
    endtask

    task automatic cs_low();
        adc_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        adc_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    // Runs n SCLK periods. Address bits go out before rises 3..5.
    // Bit i is sampled just before rise i.
    task automatic run_bits(input logic [2:0] addr, input int n, output logic [15:0] data);
        data = '0;
        for (int i = 1; i <= n; i++) begin
            if (i >= 3 && i <= 5) adc_saddr = addr[5-i];
            else adc_saddr = 1'b0;
            wait_clk(HALF);
            data[16-i] = adc_sdat;
            adc_sclk = 1'b1;
            wait_clk(HALF);
            adc_sclk = 1'b0;
        end
        wait_clk(HALF);
    endtask

    logic [15:0] data;
    int d0, a0;

    initial begin
        sep_vec[0] = '{3'd0, 16'h0000, 3'd0};
        sep_vec[1] = '{3'd3, 16'h0000, 3'd3};
        sep_vec[2] = '{3'd7, 16'h0ABC, 3'd7};
        sep_vec[3] = '{3'd0, 16'h05A5, 3'd0};
        cont_vec[0] = '{3'd0, 16'h0001, 3'd0};
        cont_vec[1] = '{3'd1, 16'h0001, 3'd1};
        cont_vec[2] = '{3'd2, 16'h0101, 3'd2};
        cont_vec[3] = '{3'd3, 16'h0201, 3'd3};
        cont_vec[4] = '{3'd4, 16'h0301, 3'd4};
        cont_vec[5] = '{3'd5, 16'h0401, 3'd5};
        cont_vec[6] = '{3'd6, 16'h0501, 3'd6};
        cont_vec[7] = '{3'd7, 16'h0601, 3'd7};

        // Clock/reset
        reset_n = 1'b0; adc_sclk = 1'b0; adc_cs_n = 1'b1; adc_saddr = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wait_clk(4);
        check("reset_sdat",  {15'd0, adc_sdat}, 16'h0);
        check("reset_done",  {15'd0, frame_done}, 16'h0);
        check("reset_abort", {15'd0, frame_abort}, 16'h0);
        check("reset_faddr", {13'd0, frame_addr}, 16'h0);
        reset_n = 1'b1;
        wait_clk(4);

        // Separate frames: address pipelining
        write_ch(3'd3, 12'hABC);
        write_ch(3'd7, 12'h5A5);
        for (int k = 0; k < 4; k++) begin
            d0 = done_cnt;
            cs_low();
            run_bits(sep_vec[k].addr, 16, data);
            cs_high();
            check($sformatf("sep_data[%0d]", k), data, sep_vec[k].exp_data);
            check($sformatf("sep_done[%0d]", k), 16'(done_cnt - d0), 16'd1);
            check($sformatf("sep_faddr[%0d]", k), {13'd0, frame_addr}, {13'd0, sep_vec[k].exp_faddr});
        end

        // Continuous frames with CS held low
        for (int i = 0; i < 8; i++) write_ch(3'(i), 12'(12'h100 * i + 1));
        a0 = abort_cnt;
        cs_low();
        for (int k = 0; k < 8; k++) begin
            d0 = done_cnt;
            run_bits(cont_vec[k].addr, 16, data);
            check($sformatf("cont_data[%0d]", k), data, cont_vec[k].exp_data);
            check($sformatf("cont_done[%0d]", k), 16'(done_cnt - d0), 16'd1);
            check($sformatf("cont_faddr[%0d]", k), {13'd0, frame_addr}, {13'd0, cont_vec[k].exp_faddr});
        end
        cs_high();
        check("clean_end_no_abort", 16'(abort_cnt - a0), 16'd0);

        // Abort after 7 SCLK periods of a frame addressing 5
        d0 = done_cnt; a0 = abort_cnt;
        cs_low();
        run_bits(3'd5, 7, data);
        cs_high();
        check("abort_pulse", 16'(abort_cnt - a0), 16'd1);
        check("abort_no_done", 16'(done_cnt - d0), 16'd0);
        check("abort_faddr", {13'd0, frame_addr}, 16'd7);
        cs_low();
        run_bits(3'd2, 16, data);
        cs_high();
        check("after_abort_data", data, 16'h0701);

        // Write ch[2] in the same clk as the CS-fall load of channel 2
        adc_cs_n = 1'b0;
        wait_clk(SYNC);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'hFFF;
        wait_clk(1);
        wr_en = 1'b0;
        wait_clk(HALF);
        run_bits(3'd2, 16, data);
        cs_high();
        check("wr_load_old", data, 16'h0201);
        cs_low();
        run_bits(3'd2, 16, data);
        cs_high();
        check("wr_load_new", data, 16'h0FFF);

        // Reset mid-frame after 9 SCLK periods
        cs_low();
        run_bits(3'd2, 9, data);
        check("pre_reset_bits", data, 16'h0F80);
        check("pre_reset_sdat", {15'd0, adc_sdat}, 16'h1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_sdat",  {15'd0, adc_sdat}, 16'h0);
        check("mid_reset_faddr", {13'd0, frame_addr}, 16'h0);
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2);
        d0 = done_cnt;
        run_bits(3'd3, 16, data);   // CS still low: must be ignored
        check("post_reset_idle_sdat", data, 16'h0000);
        check("post_reset_idle_done", 16'(done_cnt - d0), 16'd0);
        cs_high();
        d0 = done_cnt;
        cs_low();
        run_bits(3'd0, 16, data);
        cs_high();
        check("post_reset_data", data, 16'h0000);
        check("post_reset_done", 16'(done_cnt - d0), 16'd1);
        check("post_reset_faddr", {13'd0, frame_addr}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
